trng_com_rx: RTL and testbench
==============================

Name: trng_com_rx

Overview:
- Serial receiver: the inbound counterpart of the TRNG byte transmitter on the same UART-style link.
- Deserialises 8N1 frames (idle-high line, LSB first) from i_serial_data and validates start and stop bits.
- Buffers received bytes in a small first-word-fall-through FIFO for the host-command path.
- Drives o_serial_rts_n to throttle the remote sender before the FIFO overflows.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit. Even number, minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries. Power of two, minimum 2.
- LW, $clog2(FIFO_DEPTH)+1, width of o_level. Derived; do not override.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_serial_data  in  1  asynchronous serial line; idle high.
- o_serial_rts_n  out  1  low = ready to receive; high = remote sender must pause.
- i_read  in  1  pops the FIFO head when o_valid=1.
- o_dat  out  8  FIFO head byte; valid while o_valid=1.
- o_valid  out  1  FIFO not empty.
- o_level  out  LW  FIFO occupancy, 0..FIFO_DEPTH.
- o_new_frame  out  1  1-cycle pulse per byte written into the FIFO.
- o_frame_err  out  1  1-cycle pulse when a stop bit samples 0.
- o_overrun  out  1  1-cycle pulse when a good byte is dropped because the FIFO is full.
- o_parity_err  out  1  1-cycle pulse on parity mismatch (optional feature only).

Behaviour:
- Reset (async assert): sync flops=1, FSM=IDLE, counters=0, FIFO empty, o_dat=0, o_valid=0, o_level=0, all pulses=0, o_serial_rts_n=1. Reset mid-frame abandons the frame; no output pulse.
- Input sync: 2-flop synchroniser, reset to 1. "line" below means the synchroniser output, which lags the pin by 2 cycles.
- Timing reference: t0 = first cycle line=0 while in IDLE. H = CLKS_PER_BIT/2.
- Sample instants:
  - start bit at t0+H;
  - data bit k (k=0..7, LSB first) at t0+H+(k+1)*CLKS_PER_BIT;
  - stop bit at t0+H+9*CLKS_PER_BIT.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START when line=0; bit counter cleared.
  - START: at start sample, line=0 -> DATA; line=1 -> IDLE (glitch rejected silently, no pulse).
  - DATA: shift one bit per sample instant; after bit 7 -> STOP.
  - STOP, line=1 at sample: FIFO not full, or full with a pop in the same cycle -> push byte, pulse o_new_frame. Otherwise drop byte, pulse o_overrun. Either way -> IDLE.
  - STOP, line=0 at sample: drop byte, pulse o_frame_err -> BREAK.
  - BREAK: wait for line=1, then -> IDLE. A held-low line (break condition) yields exactly one o_frame_err.
- Latency:
  - o_valid, o_new_frame, o_level update on the cycle after the stop sample.
  - Pin falling edge to o_valid with CLKS_PER_BIT=16: 2+8+144+1 = 155 cycles.
- FIFO:
  - FWFT: o_dat shows the head combinationally from the registered array/pointer.
  - Pop on i_read & o_valid; i_read with o_valid=0 is ignored.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Flow control: o_serial_rts_n is registered. It is 1 when the next-cycle level >= FIFO_DEPTH-1, else 0; with FIFO_DEPTH=4 it goes high at level 3. A frame already in flight is still received.
- Pulse outputs: registered, high for exactly one cycle, mutually exclusive per frame.

Optional Feature:
- Macro: TRNG_COM_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP; parity is sampled at t0+H+9*CLKS_PER_BIT and stop moves to t0+H+10*CLKS_PER_BIT.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch the byte is dropped and o_parity_err pulses at the stop sample instead of o_new_frame; stop-bit checking still applies.
  - Frame error takes priority over parity error; only one pulse per frame.
- Undefined: 8N1 as above; o_parity_err is tied to 0.

Test Plan:
1. Frame 0xA5, 8N1, CLKS_PER_BIT=16 -> o_new_frame and o_valid rise 155 cycles after the pin falls; o_dat=0xA5; o_level=1. i_read -> o_valid=0 next cycle.
2. 5 back-to-back frames 0x01..0x05, no reads, FIFO_DEPTH=4 -> o_serial_rts_n=1 after byte 3; byte 5 raises o_overrun; FIFO drains in order 01,02,03,04.
3. Frame with stop bit 0, then line held low 100 bit times -> exactly one o_frame_err; no push; after line returns high, frame 0x3C is received correctly.
4. Low glitch of 4 cycles on an idle line -> no pulses; FSM back in IDLE; a following frame 0xFF is received correctly.
5. FIFO full, i_read asserted on the same cycle as the stop sample of frame 0x77 -> no o_overrun; level stays 4; 0x77 appears last in read order.
6. i_reset asserted during DATA bit 4, released, then frame 0x5A sent -> all outputs at reset values during reset; only 0x5A is received. With TRNG_COM_RX_PARITY_EN, 0x5A sent with parity 1 -> o_parity_err pulse, no push.

Source files
------------

// File: rtl/trng_com_rx_if.sv
// Host-side read bus of the TRNG serial receiver FIFO (first-word-fall-through).
interface trng_com_rx_if #(
    parameter int LW = 3
);
    logic          i_read;
    logic [7:0]    o_dat;
    logic          o_valid;
    logic [LW-1:0] o_level;

    modport master (output i_read, input o_dat, o_valid, o_level);
    modport slave  (input i_read, output o_dat, o_valid, o_level);
endinterface

// File: rtl/trng_com_rx.sv
// TRNG link receiver: 8N1 deserialiser, FWFT receive FIFO and RTS flow control.
// Define TRNG_COM_RX_PARITY_EN for 8E1 frames with even-parity checking.
module trng_com_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_serial_data,
    output logic          o_serial_rts_n,
    trng_com_rx_if.slave  host,
    output logic          o_new_frame,
    output logic          o_frame_err,
    output logic          o_overrun,
    output logic          o_parity_err
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_RTS  = LW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef TRNG_COM_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    sync_q;
    logic          line;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sample;
    logic          parity_ok;
    logic          push, pop, full;
    logic          new_frame_d, frame_err_d, overrun_d, parity_err_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nx;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], i_serial_data};
    end
    assign line = sync_q[1];

    // The start bit is sampled half a bit in; every later sample is a whole bit apart.
    assign sample = (state == S_START) ? (cnt == H_LAST) : (cnt == BIT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    // NOTE: default assignment first so no path through the comb block infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (!line) state_nx = S_START;
            S_START: if (sample) state_nx = line ? S_IDLE : S_DATA;
`ifdef TRNG_COM_RX_PARITY_EN
            S_DATA:   if (sample && bit_idx == 3'd7) state_nx = S_PARITY;
            S_PARITY: if (sample) state_nx = S_STOP;
`else
            S_DATA:  if (sample && bit_idx == 3'd7) state_nx = S_STOP;
`endif
            S_STOP:  if (sample) state_nx = line ? S_IDLE : S_BREAK;
            S_BREAK: if (line) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == S_IDLE || state == S_BREAK || sample) cnt <= '0;
            else                                                cnt <= cnt + 1'b1;
            if (state == S_IDLE)                bit_idx <= '0;
            else if (state == S_DATA && sample) bit_idx <= bit_idx + 1'b1;
            if (state == S_DATA && sample) shift <= {line, shift[7:1]};
        end
    end

`ifdef TRNG_COM_RX_PARITY_EN
    logic par_bit;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                          par_bit <= 1'b0;
        else if (state == S_PARITY && sample) par_bit <= line;
    end
    assign parity_ok = ~^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign full = (level == LVL_FULL);
    assign pop  = host.i_read && host.o_valid;

    // Stop-bit verdict: frame error outranks parity, a pop frees room for a full FIFO.
    always_comb begin
        push         = 1'b0;
        new_frame_d  = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        parity_err_d = 1'b0;
        if (state == S_STOP && sample) begin
            if (!line)              frame_err_d  = 1'b1;
            else if (!parity_ok)    parity_err_d = 1'b1;
            else if (!full || pop)  push         = 1'b1;
            else                    overrun_d    = 1'b1;
        end
        new_frame_d = push;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_new_frame  <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_new_frame  <= new_frame_d;
            o_frame_err  <= frame_err_d;
            o_overrun    <= overrun_d;
            o_parity_err <= parity_err_d;
        end
    end

    always_comb begin
        level_nx = level;
        if (push && !pop)      level_nx = level + 1'b1;
        else if (pop && !push) level_nx = level - 1'b1;
    end

    // NOTE: storage array has no reset; o_dat is masked while empty so stale words never show.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            o_serial_rts_n <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level          <= level_nx;
            o_serial_rts_n <= (level_nx >= LVL_RTS);
        end
    end

    assign host.o_valid = (level != '0);
    assign host.o_level = level;
    assign host.o_dat   = host.o_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_trng_com_rx.sv
// Scoreboard bench for trng_com_rx: directed frames, FIFO order check on every pop.
module tb_trng_com_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int H     = CPB / 2;
`ifdef TRNG_COM_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    localparam int LAT = 2 + H + STOP_IDX * CPB + 1;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_serial_data = 1'b1;
    logic o_serial_rts_n, o_new_frame, o_frame_err, o_overrun, o_parity_err;

    trng_com_rx_if #(.LW(LW)) host ();

    trng_com_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_serial_data  (i_serial_data),
        .o_serial_rts_n (o_serial_rts_n),
        .host           (host),
        .o_new_frame    (o_new_frame),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun),
        .o_parity_err   (o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb [$];
    int cnt_new = 0, cnt_ferr = 0, cnt_ovr = 0, cnt_perr = 0;
    int s_new, s_ferr, s_ovr, s_perr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and compares every popped byte against the scoreboard.
    always @(negedge i_clk) begin
        if (o_new_frame)  cnt_new++;
        if (o_frame_err)  cnt_ferr++;
        if (o_overrun)    cnt_ovr++;
        if (o_parity_err) cnt_perr++;
        if (host.i_read && host.o_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no byte", host.o_dat);
            end else begin
                check("rd_data", {24'h0, host.o_dat}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        i_serial_data = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        logic par;
        par = (^d) ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TRNG_COM_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic read_one();
        host.i_read = 1'b1;
        tick(1);
        host.i_read = 1'b0;
    endtask

    task automatic snap();
        s_new  = cnt_new;
        s_ferr = cnt_ferr;
        s_ovr  = cnt_ovr;
        s_perr = cnt_perr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  host.o_valid,   1'b0);
        check({tag, "_level"},  host.o_level,   '0);
        check({tag, "_dat"},    host.o_dat,     8'h00);
        check({tag, "_rts_n"},  o_serial_rts_n, 1'b1);
        check({tag, "_pulses"}, {o_new_frame, o_frame_err, o_overrun, o_parity_err}, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        host.i_read   = 1'b0;
        i_serial_data = 1'b1;
        i_reset       = 1'b1;
        tick(3);
        check_reset_outputs("rst");
        i_reset = 1'b0;
        tick(5);
        check("idle_rts_n", o_serial_rts_n, 1'b0);

        // 1: single frame, latency from pin fall to o_new_frame / o_valid
        snap();
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                int n;
                for (n = 0; n < LAT + 100; n++) begin
                    @(negedge i_clk);
                    if (o_new_frame) break;
                end
                check("t1_latency", n, LAT);
                check("t1_valid", host.o_valid, 1'b1);
                check("t1_dat", host.o_dat, 8'hA5);
                check("t1_level", host.o_level, 1);
            end
        join
        read_one();
        check("t1_valid_after_read", host.o_valid, 1'b0);
        check("t1_level_after_read", host.o_level, 0);

        // 2: five back-to-back frames, no reads
        snap();
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) sb.push_back(8'(b));
            send_frame(8'(b), 1'b1, 1'b0);
            check($sformatf("t2_rts_n_b%0d", b), o_serial_rts_n, (b >= 3) ? 1'b1 : 1'b0);
            check($sformatf("t2_level_b%0d", b), host.o_level, (b > DEPTH) ? DEPTH : b);
        end
        check("t2_overrun", cnt_ovr - s_ovr, 1);
        check("t2_new_frames", cnt_new - s_new, 4);
        repeat (4) read_one();
        check("t2_level_drained", host.o_level, 0);
        check("t2_rts_n_drained", o_serial_rts_n, 1'b0);

        // 3: bad stop bit, then a long break
        snap();
        send_frame(8'hC3, 1'b0, 1'b1);
        i_serial_data = 1'b0;
        tick(100 * CPB);
        i_serial_data = 1'b1;
        tick(2 * CPB);
        check("t3_frame_err", cnt_ferr - s_ferr, 1);
        check("t3_no_push", cnt_new - s_new, 0);
        check("t3_no_parity_err", cnt_perr - s_perr, 0);
        check("t3_level", host.o_level, 0);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("t3_recover", cnt_new - s_new, 1);
        read_one();

        // 4: short low glitch on the idle line
        snap();
        i_serial_data = 1'b0;
        tick(4);
        i_serial_data = 1'b1;
        tick(3 * CPB);
        check("t4_no_pulses", (cnt_new - s_new) + (cnt_ferr - s_ferr) + (cnt_ovr - s_ovr) + (cnt_perr - s_perr), 0);
        check("t4_level", host.o_level, 0);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("t4_frame_ff", cnt_new - s_new, 1);
        read_one();

        // 5: full FIFO, pop on the stop-sample cycle
        sb.push_back(8'h11); send_frame(8'h11, 1'b1, 1'b0);
        sb.push_back(8'h22); send_frame(8'h22, 1'b1, 1'b0);
        sb.push_back(8'h33); send_frame(8'h33, 1'b1, 1'b0);
        sb.push_back(8'h44); send_frame(8'h44, 1'b1, 1'b0);
        check("t5_full", host.o_level, DEPTH);
        snap();
        sb.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                tick(LAT - 1);
                host.i_read = 1'b1;
                tick(1);
                host.i_read = 1'b0;
            end
        join
        check("t5_no_overrun", cnt_ovr - s_ovr, 0);
        check("t5_pushed", cnt_new - s_new, 1);
        check("t5_level", host.o_level, DEPTH);
        read_one();
        read_one();
        check("t5_level_partial", host.o_level, 2);

        // 6: reset in the middle of data bit 4, with bytes still buffered
        snap();
        i_serial_data = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        i_serial_data = 1'b0;
        tick(H);
        i_reset       = 1'b1;
        i_serial_data = 1'b1;
        tick(2);
        check_reset_outputs("t6_in_reset");
        i_reset = 1'b0;
        sb.delete();
        tick(3 * CPB);
        check("t6_no_pulses", (cnt_new - s_new) + (cnt_ferr - s_ferr) + (cnt_ovr - s_ovr) + (cnt_perr - s_perr), 0);
        check("t6_level", host.o_level, 0);
`ifdef TRNG_COM_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        check("t6_parity_err", cnt_perr - s_perr, 1);
        check("t6_no_push", cnt_new - s_new, 0);
        check("t6_level_after", host.o_level, 0);
`else
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t6_new_frame", cnt_new - s_new, 1);
        check("t6_level_after", host.o_level, 1);
        read_one();
        check("t6_drained", host.o_valid, 1'b0);
`endif
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
